lsu_mem_port: RTL and testbench

Load/store access unit between the core's memory stage and the byte-addressable word RAM. It turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned RAM accesses. Sub-word stores use read-modify-write, because the RAM always writes all four bytes of a word while `write` is high. All RAM-side outputs are registered, so address and data stay stable for the whole time `mem_write` is asserted.

---
 rtl/lsu_mem_port.sv | 191 +++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port
// Load/store access unit between the core memory stage and a word-wide RAM.
// Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned RAM
// accesses. Sub-word stores perform a read-modify-write because the RAM
// always writes a full word while mem_write is high.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready request handshake (accept when both high in IDLE)
//   req_we, req_funct3  store/load select and RISC-V access size/sign
//   req_addr, req_wdata byte address and right-justified store data
//   rsp_valid           one-cycle response pulse, no backpressure
//   rsp_rdata, rsp_err  load result / error flag, zero outside rsp_valid
//   mem_addr, mem_wdata registered word address and merged write word
//   mem_read, mem_write strobes decoded from registered state
//   mem_rdata           combinational RAM read data for mem_addr
module lsu_mem_port #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP,
        S_ERR
    } state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rsp_rdata_q;

    // Request decode, only meaningful on the accept edge.
    logic        accept;
    logic        illegal;
    logic        misalign;
    logic [1:0]  off_d;

    always_comb begin
        accept   = (state_q == S_IDLE) && req_valid && req_ready_q;
        illegal  = req_we ? (req_funct3 > 3'd2)
                          : ((req_funct3 == 3'd3) || (req_funct3 >= 3'd6));
        misalign = CHECK_ALIGN &&
                   (((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00)));
        // With alignment checking off, the offset is forced to the natural
        // alignment of the access so lane selection stays within the word.
        case (req_funct3[1:0])
            2'd1:    off_d = {req_addr[1], 1'b0};
            2'd2:    off_d = 2'b00;
            default: off_d = req_addr[1:0];
        endcase
    end

    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {off, 3'b000};
        b = shifted[7:0];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    load_extract = {{24{b[7]}}, b};
            3'd1:    load_extract = {{16{h[15]}}, h};
            3'd4:    load_extract = {24'd0, b};
            3'd5:    load_extract = {16'd0, h};
            default: load_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word,
                                                input logic [31:0] wd);
        logic [31:0] merged;
        merged = word;
        case (f3[1:0])
            2'd0: begin
                case (off)
                    2'd0:    merged[7:0]   = wd[7:0];
                    2'd1:    merged[15:8]  = wd[7:0];
                    2'd2:    merged[23:16] = wd[7:0];
                    default: merged[31:24] = wd[7:0];
                endcase
            end
            2'd1: begin
                if (off[1]) merged[31:16] = wd[15:0];
                else        merged[15:0]  = wd[15:0];
            end
            default: merged = wd;
        endcase
        return merged;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            wdata_q     <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rsp_rdata_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // First edge after reset release raises ready.
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        funct3_q    <= req_funct3;
                        off_q       <= off_d;
                        wdata_q     <= req_wdata;
                        mem_addr_q  <= {req_addr[31:2], 2'b00};
                        if (illegal || misalign) begin
                            state_q <= S_ERR;
                        end else if (req_we && (req_funct3 == 3'd2)) begin
                            // Full word store needs no read.
                            mem_wdata_q <= req_wdata;
                            state_q     <= S_WR;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (we_q) begin
                        mem_wdata_q <= store_merge(funct3_q, off_q, mem_rdata, wdata_q);
                        state_q     <= S_WR;
                    end else begin
                        rsp_rdata_q <= load_extract(funct3_q, off_q, mem_rdata);
                        state_q     <= S_RESP;
                    end
                end
                S_WR: begin
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    rsp_rdata_q <= 32'd0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_ERR: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = (state_q == S_RESP) || (state_q == S_ERR);
    assign rsp_err   = (state_q == S_ERR);
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = (state_q == S_RD);
    assign mem_write = (state_q == S_WR);

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    int checks = 0;
    int passes = 0;

    logic [31:0] ram [0:255];

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) ram[mem_addr[9:2]] <= mem_wdata;

    lsu_mem_port #(.CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ready, presents a request and returns 1ns after the
    // accept edge, i.e. sampling point of cycle 1.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
        else passes++;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        step();
        req_valid  = 1'b0;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h0BAD_0BAD;
        $display("req we=%0d f3=%0d addr=%08h wdata=%08h", we, f3, addr, wd);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mem_read, mem_write} !== 5'b0 ||
            rsp_rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0)
            $display("FAIL reset_outputs: ready=%b rv=%b err=%b rd=%b wr=%b rdata=%08h addr=%08h wdata=%08h required all 0",
                     req_ready, rsp_valid, rsp_err, mem_read, mem_write, rsp_rdata, mem_addr, mem_wdata);
        else passes++;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) $display("FAIL ready_before_edge: %b required 0", req_ready);
        else passes++;
        step();
        checks++;
        if (req_ready !== 1'b1) $display("FAIL ready_after_release: %b required 1", req_ready);
        else passes++;
        $display("reset released, req_ready=%b", req_ready);
    endtask

    task automatic test_word();
        issue(1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF)
            $display("FAIL sw_cycle1: wr=%b rd=%b addr=%08h wdata=%08h required 1 0 00000100 deadbeef",
                     mem_write, mem_read, mem_addr, mem_wdata);
        else passes++;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0 || mem_write !== 1'b0)
            $display("FAIL sw_resp: rv=%b err=%b rdata=%08h wr=%b required 1 0 0 0",
                     rsp_valid, rsp_err, rsp_rdata, mem_write);
        else passes++;
        step();
        checks++;
        if (rsp_valid !== 1'b0) $display("FAIL sw_resp_pulse: rv=%b required 0", rsp_valid);
        else passes++;

        issue(1'b0, 3'd2, 32'h100, 32'd0);
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL lw_cycle1: rd=%b wr=%b rv=%b required 1 0 0", mem_read, mem_write, rsp_valid);
        else passes++;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF)
            $display("FAIL lw_resp: rv=%b err=%b rdata=%08h required 1 0 deadbeef", rsp_valid, rsp_err, rsp_rdata);
        else passes++;
        step();
        checks++;
        if (rsp_rdata !== 32'd0) $display("FAIL lw_rdata_cleared: %08h required 0", rsp_rdata);
        else passes++;
    endtask

    // Sub-word store: RD in cycle 1, WR in cycle 2, response in cycle 3.
    task automatic test_subword_stores();
        logic [2:0]  f3s  [2] = '{3'd0, 3'd1};
        logic [31:0] adrs [2] = '{32'h101, 32'h102};
        logic [31:0] wds  [2] = '{32'hFFFF_FF55, 32'h1234_8001};
        logic [31:0] exps [2] = '{32'hDEAD55EF, 32'h800155EF};
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, f3s[i], adrs[i], wds[i]);
            checks++;
            if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h100)
                $display("FAIL sub_store_rd[%0d]: rd=%b wr=%b addr=%08h required 1 0 00000100", i, mem_read, mem_write, mem_addr);
            else passes++;
            step();
            checks++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== exps[i] || mem_addr !== 32'h100)
                $display("FAIL sub_store_wr[%0d]: wr=%b rd=%b wdata=%08h addr=%08h required 1 0 %08h 00000100",
                         i, mem_write, mem_read, mem_wdata, mem_addr, exps[i]);
            else passes++;
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || mem_write !== 1'b0 || mem_wdata !== exps[i])
                $display("FAIL sub_store_resp[%0d]: rv=%b err=%b wr=%b wdata=%08h required 1 0 0 %08h",
                         i, rsp_valid, rsp_err, mem_write, mem_wdata, exps[i]);
            else passes++;
            if (i == 0) begin
                // Byte loads between the SB and the SH, memory word 0xDEAD55EF.
                for (int k = 0; k < 2; k++) begin
                    logic [2:0]  lf3 [2] = '{3'd0, 3'd4};
                    logic [31:0] lex [2] = '{32'hFFFFFFDE, 32'h000000DE};
                    issue(1'b0, lf3[k], 32'h103, 32'd0);
                    step();
                    checks++;
                    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== lex[k])
                        $display("FAIL byte_load[%0d]: rv=%b err=%b rdata=%08h required 1 0 %08h",
                                 k, rsp_valid, rsp_err, rsp_rdata, lex[k]);
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_half_loads();
        logic [2:0]  f3s  [3] = '{3'd1, 3'd5, 3'd1};
        logic [31:0] adrs [3] = '{32'h102, 32'h102, 32'h100};
        logic [31:0] exps [3] = '{32'hFFFF8001, 32'h00008001, 32'h000055EF};
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, f3s[i], adrs[i], 32'd0);
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== exps[i])
                $display("FAIL half_load[%0d]: rv=%b err=%b rdata=%08h required 1 0 %08h",
                         i, rsp_valid, rsp_err, rsp_rdata, exps[i]);
            else passes++;
        end
    endtask

    task automatic test_errors();
        logic [2:0]  f3s  [3] = '{3'd2, 3'd3, 3'd1};
        logic [31:0] adrs [3] = '{32'h102, 32'h100, 32'h101};
        logic        wes  [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            issue(wes[i], f3s[i], adrs[i], 32'h5A5A5A5A);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0 ||
                mem_read !== 1'b0 || mem_write !== 1'b0)
                $display("FAIL err_resp[%0d]: rv=%b err=%b rdata=%08h rd=%b wr=%b required 1 1 0 0 0",
                         i, rsp_valid, rsp_err, rsp_rdata, mem_read, mem_write);
            else passes++;
            step();
            checks++;
            if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b1)
                $display("FAIL err_after[%0d]: rv=%b err=%b rd=%b wr=%b ready=%b required 0 0 0 0 1",
                         i, rsp_valid, rsp_err, mem_read, mem_write, req_ready);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_store();
        logic seen_rsp;
        issue(1'b1, 3'd2, 32'h200, 32'h11223344);
        step();
        step();
        issue(1'b1, 3'd0, 32'h200, 32'h000000AA);
        step();
        checks++;
        if (mem_write !== 1'b1) $display("FAIL mid_store_wr: wr=%b required 1", mem_write);
        else passes++;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || req_ready !== 1'b0)
            $display("FAIL mid_store_reset: wr=%b addr=%08h wdata=%08h ready=%b required 0 0 0 0",
                     mem_write, mem_addr, mem_wdata, req_ready);
        else passes++;
        seen_rsp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rsp_valid) seen_rsp = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rsp_valid) seen_rsp = 1'b1;
        end
        checks++;
        if (seen_rsp !== 1'b0) $display("FAIL mid_store_no_rsp: rsp_valid seen=%b required 0", seen_rsp);
        else passes++;
        issue(1'b0, 3'd2, 32'h200, 32'd0);
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h11223344)
            $display("FAIL mid_store_lw: rv=%b err=%b rdata=%08h required 1 0 11223344",
                     rsp_valid, rsp_err, rsp_rdata);
        else passes++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
        test_reset();
        test_word();
        test_subword_stores();
        test_half_loads();
        test_errors();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
